// File: rtl/ram_burst_writer.sv
// ram_burst_writer: snapshots a wide source word on start and writes it byte by
// byte into a byte-wide single-port RAM with configurable strobe/gap timing.
// Optional feature: define RAM_BURST_WRITER_CHECKSUM_EN to add an 8-bit XOR
// checksum output covering the bytes written in the current burst.
module ram_burst_writer #(
    parameter int NUM_BYTES  = 32,
    parameter int ADDR_W     = 15,
    parameter int WE_CYCLES  = 2,
    parameter int GAP_CYCLES = 1,
    parameter int LEN_W      = 6
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_BYTES*8-1:0] src,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       len,
    input  logic                   msb_first,
    output logic [7:0]             data,
    output logic [ADDR_W-1:0]      address,
    output logic                   wea,
    output logic                   busy,
    output logic                   done
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    ,
    output logic [7:0]             checksum
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    // The wait counter only needs to reach the longer of the two phases.
    localparam int CNT_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(NUM_BYTES);

    state_t                 state_q, state_d;
    logic [NUM_BYTES*8-1:0] src_q, src_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             data_d;
    logic [ADDR_W-1:0]      address_d;
    logic                   wea_d, busy_d, done_d;
    logic [7:0]             sum_q, sum_d;

    logic [NUM_BYTES*8-1:0] src_ordered;
    logic [LEN_W-1:0]       eff_len;
    logic [LEN_W-1:0]       next_idx;
    logic [7:0]             next_byte;
    logic                   last_byte;

    // Reverse byte order so the snapshot is always consumed from byte 0 upward.
    function automatic logic [NUM_BYTES*8-1:0] reverse_bytes(input logic [NUM_BYTES*8-1:0] w);
        logic [NUM_BYTES*8-1:0] r;
        r = '0;
        for (int b = 0; b < NUM_BYTES; b++)
            r[b*8 +: 8] = w[(NUM_BYTES-1-b)*8 +: 8];
        return r;
    endfunction

    // Pick byte i out of the snapshot (mux over all byte lanes).
    function automatic logic [7:0] byte_at(input logic [NUM_BYTES*8-1:0] w,
                                           input logic [LEN_W-1:0] i);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < NUM_BYTES; b++)
            if (i == LEN_W'(b)) r = w[b*8 +: 8];
        return r;
    endfunction

    // Next-state and next-output logic for the IDLE/WRITE/GAP sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        src_d     = src_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        data_d    = data;
        address_d = address;
        wea_d     = wea;
        busy_d    = busy;
        done_d    = done;
        sum_d     = sum_q;

        src_ordered = msb_first ? reverse_bytes(src) : src;
        eff_len     = (len > MAX_LEN) ? MAX_LEN : len;
        next_idx    = idx_q + LEN_W'(1);
        next_byte   = byte_at(src_q, next_idx);
        last_byte   = (idx_q == len_q - LEN_W'(1));

        case (state_q)
            IDLE: begin
                if (done && !start) begin
                    done_d = 1'b0;
                end else if (start && !done && !abort) begin
                    src_d = src_ordered;
                    len_d = eff_len;
                    idx_d = '0;
                    cnt_d = '0;
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                        sum_d  = '0;
                    end else begin
                        state_d   = WRITE;
                        data_d    = src_ordered[7:0];
                        address_d = base_addr;
                        wea_d     = 1'b1;
                        busy_d    = 1'b1;
                        sum_d     = src_ordered[7:0];
                    end
                end
            end
            WRITE, GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    wea_d   = 1'b0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (state_q == WRITE && cnt_q != WE_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (state_q == GAP && cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (state_q == WRITE && GAP_CYCLES > 0) begin
                    cnt_d   = '0;
                    wea_d   = 1'b0;
                    state_d = GAP;
                end else if (last_byte) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    wea_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d     = '0;
                    idx_d     = next_idx;
                    data_d    = next_byte;
                    address_d = address + ADDR_W'(1);
                    wea_d     = 1'b1;
                    sum_d     = sum_q ^ next_byte;
                    state_d   = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
                wea_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers; reset kills any burst in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data    <= '0;
            address <= '0;
            wea     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            src_q   <= src_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data    <= data_d;
            address <= address_d;
            wea     <= wea_d;
            busy    <= busy_d;
            done    <= done_d;
            sum_q   <= sum_d;
        end
    end

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    assign checksum = sum_q;
`else
    // Without the checksum port the running XOR has no observer and is trimmed.
    logic unused_sum;
    assign unused_sum = ^sum_q;
`endif

endmodule

// File: tb/tb_ram_burst_writer.sv
// tb_ram_burst_writer: directed self-checking bench for ram_burst_writer
// (default timing instance plus a WE_CYCLES=1 / GAP_CYCLES=0 instance).
module tb_ram_burst_writer;

    localparam int NB = 32;
    localparam int AW = 15;
    localparam int LW = 6;

    logic           sys_clk   = 1'b0;
    logic           sys_rst   = 1'b1;
    logic           start     = 1'b0;
    logic           start_b   = 1'b0;
    logic           abort     = 1'b0;
    logic           abort_b   = 1'b0;
    logic           msb_first = 1'b1;
    logic [NB*8-1:0] src      = '0;
    logic [AW-1:0]  base_addr = '0;
    logic [LW-1:0]  len       = '0;

    logic [7:0]     data, b_data;
    logic [AW-1:0]  address, b_address;
    logic           wea, busy, done, b_wea, b_busy, b_done;
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    logic [7:0]     checksum, b_checksum;
`endif

    int checks   = 0;
    int failures = 0;

    ram_burst_writer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
        .src(src), .base_addr(base_addr), .len(len), .msb_first(msb_first),
        .data(data), .address(address), .wea(wea), .busy(busy), .done(done)
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    ram_burst_writer #(.WE_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_b), .abort(abort_b),
        .src(src), .base_addr(base_addr), .len(len), .msb_first(msb_first),
        .data(b_data), .address(b_address), .wea(b_wea), .busy(b_busy), .done(b_done)
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        , .checksum(b_checksum)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte k of the burst, taken from the bench's own copy of src.
    function automatic logic [7:0] exp_byte(input int k);
        return msb_first ? src[(NB-1-k)*8 +: 8] : src[k*8 +: 8];
    endfunction

    // Run one burst on the default instance (WE=2, GAP=1) and check every edge.
    task automatic burst(input logic [AW-1:0] b, input int n, input bit hold);
        logic [AW-1:0] ea;
        int k;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int e = 0; e < n*3; e++) begin
            k  = e / 3;
            ea = b + AW'(k);
            check("wea", {31'd0, wea}, {31'd0, (e % 3) < 2});
            check("data", {24'd0, data}, {24'd0, exp_byte(k)});
            check("addr", {17'd0, address}, {17'd0, ea});
            check("busy", {31'd0, busy}, 32'd1);
            check("done_low", {31'd0, done}, 32'd0);
            tick();
        end
        check("done_end", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("wea_end", {31'd0, wea}, 32'd0);
    endtask

    initial begin
        // src = 0x00_01_02_..._1F (byte 0x00 in the top lane)
        for (int b = 0; b < NB; b++) src[(NB-1-b)*8 +: 8] = 8'(b);

        // Reset state
        #12;
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_addr", {17'd0, address}, 32'd0);
        check("rst_wea", {31'd0, wea}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_b_wea", {31'd0, b_wea}, 32'd0);
        sys_rst = 1'b0;
        tick();

        // Full 32-byte msb-first burst, start held until done
        msb_first = 1'b1; base_addr = '0; len = 6'd32;
        burst(15'h0000, 32, 1'b1);
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        check("cksum_32", {24'd0, checksum}, 32'd0);
`endif
        start = 1'b0;
        tick();
        check("done_clear", {31'd0, done}, 32'd0);

        // lsb-first, base 0x100, len 4; start held -> no second burst
        msb_first = 1'b0; base_addr = 15'h0100; len = 6'd4;
        burst(15'h0100, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_busy", {31'd0, busy}, 32'd0);
            check("held_wea", {31'd0, wea}, 32'd0);
            check("held_done", {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        tick();
        check("done_clear2", {31'd0, done}, 32'd0);

        // Address wrap; start dropped mid-burst -> one-cycle done pulse
        msb_first = 1'b1; base_addr = 15'h7FFE; len = 6'd4;
        burst(15'h7FFE, 4, 1'b0);
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);

        // len = 0 -> done on the start edge, no write
        len = 6'd0;
        start = 1'b1;
        tick();
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_wea", {31'd0, wea}, 32'd0);
        check("len0_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        tick();
        check("len0_clear", {31'd0, done}, 32'd0);

        // len = 40 clamps to 32 bytes
        base_addr = 15'h0000; len = 6'd40;
        burst(15'h0000, 32, 1'b0);
        tick();

        // Abort during byte 5
        len = 6'd32;
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("pre_abort_wea", {31'd0, wea}, 32'd1);
        check("pre_abort_data", {24'd0, data}, 32'd5);
        check("pre_abort_addr", {17'd0, address}, 32'd5);
        abort = 1'b1; start = 1'b0;
        tick();
        check("abort_wea", {31'd0, wea}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        abort = 1'b0;
        tick();
        check("post_abort_done", {31'd0, done}, 32'd0);

        // abort in IDLE blocks a start on the same edge
        start = 1'b1; abort = 1'b1;
        tick();
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_wea", {31'd0, wea}, 32'd0);
        start = 1'b0; abort = 1'b0;
        tick();

        // Reset mid-burst, then a full fresh burst
        start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, data}, 32'd0);
        check("mid_rst_addr", {17'd0, address}, 32'd0);
        check("mid_rst_wea", {31'd0, wea}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        check("post_rst_done", {31'd0, done}, 32'd0);
        burst(15'h0000, 32, 1'b0);
        tick();

        // WE_CYCLES=1, GAP_CYCLES=0 instance: back-to-back strobes
        base_addr = 15'h0010; len = 6'd3; msb_first = 1'b1;
        start_b = 1'b1;
        tick();
        for (int e = 0; e < 3; e++) begin
            check("b_wea", {31'd0, b_wea}, 32'd1);
            check("b_addr", {17'd0, b_address}, 32'h10 + 32'(e));
            check("b_data", {24'd0, b_data}, 32'(e));
            check("b_busy", {31'd0, b_busy}, 32'd1);
            tick();
        end
        check("b_done", {31'd0, b_done}, 32'd1);
        check("b_wea_end", {31'd0, b_wea}, 32'd0);
        check("b_busy_end", {31'd0, b_busy}, 32'd0);
        start_b = 1'b0;
        tick();
        check("b_done_clear", {31'd0, b_done}, 32'd0);

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        // Bytes 0x01, 0x02, 0x04 -> checksum 0x07
        src = '0;
        src[7:0] = 8'h01; src[15:8] = 8'h02; src[23:16] = 8'h04;
        msb_first = 1'b0; base_addr = '0; len = 6'd3;
        burst(15'h0000, 3, 1'b0);
        check("cksum_3", {24'd0, checksum}, 32'h07);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_burst_writer.md
Name: ram_burst_writer

Overview:
- Parametrised successor to the fixed 32-byte hash-to-RAM writer in the verify path.
- Snapshots a wide source word (hash, commitment, seed, ...) on start and serialises it byte-by-byte into a byte-wide single-port block RAM.
- Runtime base address, length and byte order; configurable write-enable strobe and gap timing; done/start level handshake; synchronous abort.

Parameters:
- NUM_BYTES, 32, bytes in src; max burst length.
- ADDR_W, 15, RAM address width.
- WE_CYCLES, 2, cycles wea is held per byte (>=1).
- GAP_CYCLES, 1, cycles wea is low after each byte (>=0).
- LEN_W, 6, width of len; must hold NUM_BYTES.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous active-high reset.
- start  in  1  level request; sampled in IDLE.
- abort  in  1  synchronous cancel.
- src  in  NUM_BYTES*8  source word.
- base_addr  in  ADDR_W  first RAM address.
- len  in  LEN_W  bytes to write.
- msb_first  in  1  1: byte0 = src[top 8 bits]; 0: byte0 = src[7:0].
- data  out  8  RAM write data.
- address  out  ADDR_W  RAM address.
- wea  out  1  RAM write enable.
- busy  out  1  burst in progress.
- done  out  1  completion flag; level, held until start is low.

Behaviour:
- Reset (async, sys_rst=1): data=0, address=0, wea=0, busy=0, done=0, state=IDLE, byte index=0, wait counter=0. Reset mid-burst kills the burst immediately; no done is produced.
- States: IDLE, WRITE, GAP.
- IDLE: on an edge with start=1, done=0 and abort=0:
  - latch src, base_addr, msb_first and eff_len = min(len, NUM_BYTES);
  - busy<=1;
  - if eff_len=0: busy<=0 and done<=1 on the same edge, no write;
  - else enter WRITE with data=byte0, address=base_addr, wea=1.
- WRITE: wea held high for WE_CYCLES edges; data/address stable throughout.
  - GAP_CYCLES>0: then wea<=0 and enter GAP.
  - GAP_CYCLES=0: go directly to the next byte (wea stays 1, data/address update) or finish.
- GAP: wea=0 for GAP_CYCLES edges; data/address hold the last values. Then load the next byte: index+1, address<=base+index+1, wea<=1, back to WRITE.
- Address arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
- Finish: the edge ending the last byte's GAP (or WRITE if GAP_CYCLES=0) sets wea<=0, busy<=0, done<=1, state<=IDLE.
- Timing: with start sampled at edge 0, byte k has wea high after edges k*(WE+GAP) .. k*(WE+GAP)+WE-1. done rises at edge eff_len*(WE_CYCLES+GAP_CYCLES).
- done handshake:
  - done clears on the first edge with start=0.
  - While done=1, start is ignored, so each burst needs start to drop and rise again.
  - If start drops mid-burst, the burst still completes; done then pulses for one cycle and clears.
- abort=1 in WRITE/GAP: next edge wea<=0, busy<=0, state<=IDLE, done stays 0. In IDLE, abort blocks a start on the same edge.
- src, base_addr, len and msb_first changing during a burst have no effect; all are snapshotted at start.

Optional Feature:
- Macro: RAM_BURST_WRITER_CHECKSUM_EN.
- Defined:
  - adds output port checksum (8 bits), the XOR of every byte written in the current burst;
  - cleared to 0 on reset and on burst start;
  - updated on each byte's first wea cycle;
  - valid when done=1; unchanged on abort (partial value).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults; src=0x00010203...1F, base=0, len=32, msb_first=1 -> 32 writes addr 0..31 with data 0x00..0x1F; each wea high exactly 2 cycles, 1 low; done rises 96 cycles after start edge.
- Same src, msb_first=0, base=0x100, len=4 -> addr 0x100..0x103 with data 0x1F,0x1E,0x1D,0x1C; done at edge 12; start held high -> no second burst until start drops and rises again.
- base=0x7FFE, len=4 -> addresses 0x7FFE,0x7FFF,0x0000,0x0001; len=0 -> done next edge, wea never asserted; len=40 -> clamped to 32 writes.
- GAP_CYCLES=0, WE_CYCLES=1, len=3 -> wea high 3 consecutive cycles, address steps each cycle, done at edge 3.
- abort asserted during byte 5 -> wea low next edge, busy=0, done stays 0; sys_rst pulsed mid-burst -> all outputs 0 asynchronously; a fresh start then runs a full burst.
- With RAM_BURST_WRITER_CHECKSUM_EN, bytes 0x00..0x1F -> checksum=0x00; bytes 0x01,0x02,0x04 (len=3) -> checksum=0x07.
